// File: rtl/fft4_frame_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared definitions for the 4-point FFT datapath: default word
//            and fraction widths, unity twiddle, bank state encoding and the
//            complex sample record.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

  // Default sample/twiddle word width and number of fractional bits
  localparam int N_DEF = 16;
  localparam int Q_DEF = 8;

  // Unity in Q-format for a given number of fractional bits
  function automatic int tw_one_f(input int q);
    return 1 << q;
  endfunction

  // Unity twiddle at the default fraction width
  localparam int TW_ONE = 1 << Q_DEF;

  // Occupancy state of one 4-entry frame bank
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  // Complex sample at the default word width
  typedef struct packed {
    logic [N_DEF-1:0] re;
    logic [N_DEF-1:0] im;
  } cplx_t;

endpackage
`default_nettype wire

// File: rtl/fft4_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : fft4_frame_loader_if
// Brief    : Sample stream in, parallel frame out, for the FFT frame loader.
//            The slave modport is the loader's view, master is the
//            environment driving samples and consuming frames.
// Revision : 1.0 - initial release
// ============================================================================
interface fft4_frame_loader_if
  import fft_pkg::*;
#(
  parameter int N = N_DEF
);

  // Sample stream
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_r;
  logic [N-1:0] in_i;
  logic         in_last;

  // Frame presentation to the butterfly stage
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] x0_r;
  logic [N-1:0] x0_i;
  logic [N-1:0] x1_r;
  logic [N-1:0] x1_i;
  logic [N-1:0] x2_r;
  logic [N-1:0] x2_i;
  logic [N-1:0] x3_r;
  logic [N-1:0] x3_i;
  logic [N-1:0] tw1_r;
  logic [N-1:0] tw1_i;
  logic [N-1:0] tw2_r;
  logic [N-1:0] tw2_i;

  // Framing error pulse
  logic         frame_err;

  modport slave (
    input  in_valid, in_r, in_i, in_last, out_ready,
    output in_ready, out_valid,
    output x0_r, x0_i, x1_r, x1_i, x2_r, x2_i, x3_r, x3_i,
    output tw1_r, tw1_i, tw2_r, tw2_i,
    output frame_err
  );

  modport master (
    output in_valid, in_r, in_i, in_last, out_ready,
    input  in_ready, out_valid,
    input  x0_r, x0_i, x1_r, x1_i, x2_r, x2_i, x3_r, x3_i,
    input  tw1_r, tw1_i, tw2_r, tw2_i,
    input  frame_err
  );

endinterface
`default_nettype wire

// File: rtl/fft4_frame_loader_bank.sv
`default_nettype none
// ============================================================================
// Module   : fft4_bank
// Brief    : One 4-entry complex register bank with occupancy state.
//            A write either stores a sample (advancing to FILLING, or FULL
//            on the last slot) or aborts the partial frame back to EMPTY.
//            A release empties a FULL bank once its frame is consumed.
// Revision : 1.0 - initial release
// ============================================================================
module fft4_bank
  import fft_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_idx,
  input  logic [N-1:0]      wr_r,
  input  logic [N-1:0]      wr_i,
  input  logic              wr_last_slot,
  input  logic              wr_abort,
  input  logic              rd_release,
  output bank_state_t       state,
  output logic [3:0][N-1:0] d_r,
  output logic [3:0][N-1:0] d_i
);

  bank_state_t       r_state;
  logic [3:0][N-1:0] r_d_r;
  logic [3:0][N-1:0] r_d_i;

  // Occupancy: writes and releases never target the same bank in one cycle,
  // since the writer skips FULL banks and only FULL banks are released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else if (wr_en) begin
      if (wr_abort) begin
        r_state <= EMPTY;
      end else if (wr_last_slot) begin
        r_state <= FULL;
      end else begin
        r_state <= FILLING;
      end
    end else if (rd_release) begin
      r_state <= EMPTY;
    end
  end

  // Sample storage; an aborting write leaves the discarded slot untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_r <= '0;
      r_d_i <= '0;
    end else if (wr_en && !wr_abort) begin
      r_d_r[wr_idx] <= wr_r;
      r_d_i[wr_idx] <= wr_i;
    end
  end

  assign state = r_state;
  assign d_r   = r_d_r;
  assign d_i   = r_d_i;

endmodule
`default_nettype wire

// File: rtl/fft4_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : fft4_frame_loader
// Brief    : Input stage of the 4-point FFT. Collects complex samples into
//            4-sample frames in a ping-pong pair of banks and presents each
//            frame in parallel, with its first-stage twiddles (W4^0), to
//            the butterfly stage under a valid/ready handshake.
//            Optional build macro FRAME_SCALE_EN: halve each sample on
//            capture with round-half-up, saturating the largest positive
//            value, to leave headroom for butterfly growth.
// Revision : 1.0 - initial release
// ============================================================================
module fft4_frame_loader
  import fft_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic               clk,
  input  logic               rst,
  fft4_frame_loader_if.slave bus
);

  localparam logic [N-1:0] C_TW_ONE = N'(tw_one_f(Q));

  logic [1:0]        r_cnt;
  logic              r_wb;
  logic              r_rb;
  logic              r_frame_err;

  bank_state_t       w_state [2];
  logic [3:0][N-1:0] w_dr    [2];
  logic [3:0][N-1:0] w_di    [2];

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_last_slot;
  logic              w_abort;
  logic              w_err;
  logic [N-1:0]      w_cap_r;
  logic [N-1:0]      w_cap_i;

`ifdef FRAME_SCALE_EN
  // Halve with round-half-up; the largest positive code would round up
  // past the halved range, so it is pinned just below it instead.
  function automatic logic [N-1:0] scale_f(input logic [N-1:0] v);
    logic [N:0] sum;
    sum = '0;
    if (v == {1'b0, {(N-1){1'b1}}}) begin
      scale_f = {2'b00, {(N-2){1'b1}}};
    end else begin
      sum     = {v[N-1], v} + {{N{1'b0}}, 1'b1};
      scale_f = sum[N:1];
    end
  endfunction

  assign w_cap_r = scale_f(bus.in_r);
  assign w_cap_i = scale_f(bus.in_i);
`else
  assign w_cap_r = bus.in_r;
  assign w_cap_i = bus.in_i;
`endif

  // Handshakes depend only on registered bank state, so in_ready never
  // sees out_ready combinationally.
  assign w_in_ready  = (w_state[r_wb] != FULL);
  assign w_out_valid = (w_state[r_rb] == FULL);
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  // Framing: early in_last drops the partial frame; a missing in_last on
  // the 4th sample still completes the frame but is flagged.
  assign w_last_slot = (r_cnt == 2'd3);
  assign w_abort     = bus.in_last & ~w_last_slot;
  assign w_err       = w_in_fire & (w_abort | (w_last_slot & ~bus.in_last));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft4_bank #(
      .N (N)
    ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (w_in_fire && (r_wb == 1'(b))),
      .wr_idx       (r_cnt),
      .wr_r         (w_cap_r),
      .wr_i         (w_cap_i),
      .wr_last_slot (w_last_slot),
      .wr_abort     (w_abort),
      .rd_release   (w_out_fire && (r_rb == 1'(b))),
      .state        (w_state[b]),
      .d_r          (w_dr[b]),
      .d_i          (w_di[b])
    );
  end

  // Write-side sequencing: sample counter, write bank toggle on frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 2'd0;
      r_wb  <= 1'b0;
    end else if (w_in_fire) begin
      if (w_abort) begin
        r_cnt <= 2'd0;
      end else if (w_last_slot) begin
        r_cnt <= 2'd0;
        r_wb  <= ~r_wb;
      end else begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  // Read-side sequencing: move to the other bank once a frame is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rb <= 1'b0;
    end else if (w_out_fire) begin
      r_rb <= ~r_rb;
    end
  end

  // Framing error is reported as a single-cycle pulse after the sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.frame_err = r_frame_err;

  // Frame data comes straight from the read bank, so it is held for as
  // long as that bank stays FULL.
  assign bus.x0_r = w_dr[r_rb][0];
  assign bus.x0_i = w_di[r_rb][0];
  assign bus.x1_r = w_dr[r_rb][1];
  assign bus.x1_i = w_di[r_rb][1];
  assign bus.x2_r = w_dr[r_rb][2];
  assign bus.x2_i = w_di[r_rb][2];
  assign bus.x3_r = w_dr[r_rb][3];
  assign bus.x3_i = w_di[r_rb][3];

  // First radix-2 stage uses W4^0 for both twiddles
  assign bus.tw1_r = C_TW_ONE;
  assign bus.tw1_i = '0;
  assign bus.tw2_r = C_TW_ONE;
  assign bus.tw2_i = '0;

endmodule
`default_nettype wire

// File: tb/tb_fft4_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft4_frame_loader
// Brief    : Self-checking bench for fft4_frame_loader. Samples come from a
//            table; completed frames are predicted into a scoreboard queue
//            and compared as the loader hands them over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft4_frame_loader;
  import fft_pkg::*;

  typedef struct packed {
    cplx_t [3:0] s;
  } frame_t;

  typedef struct {
    logic [15:0] r;
    logic [15:0] i;
    logic        last;
    logic        exp_err;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     n_checks = 0;
  int     n_fail = 0;
  int     n_err_seen = 0;
  frame_t sb[$];
  cplx_t  m_buf[4];
  int     m_cnt = 0;
  vec_t   tbl[18];

  fft4_frame_loader_if #(.N(16)) bus ();

  fft4_frame_loader #(
    .N (16),
    .Q (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sc(input logic [15:0] v);
`ifdef FRAME_SCALE_EN
    int t;
    if (v == 16'h7FFF) return 16'h3FFF;
    t = $signed(v);
    t = (t + 1) >>> 1;
    return t[15:0];
`else
    return v;
`endif
  endfunction

  // Reference framing: push a frame when the 4th sample lands
  task automatic model_accept(input logic [15:0] r, input logic [15:0] i, input logic last);
    frame_t f;
    m_buf[m_cnt].re = sc(r);
    m_buf[m_cnt].im = sc(i);
    if (last && m_cnt != 3) begin
      m_cnt = 0;
    end else if (m_cnt == 3) begin
      for (int k = 0; k < 4; k++) f.s[k] = m_buf[k];
      sb.push_back(f);
      m_cnt = 0;
      check("out_valid_latency", 32'(bus.out_valid), 32'd1);
    end else begin
      m_cnt++;
    end
  endtask

  task automatic send(input logic [15:0] r, input logic [15:0] i, input logic last,
                      input logic exp_err);
    int waited;
    bit ok;
    waited = 0;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_r     = r;
    bus.in_i     = i;
    bus.in_last  = last;
    while (!ok && waited < 100) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: sample %0h not accepted within 100 cycles", r);
    end else begin
      check("frame_err_after_accept", 32'(bus.frame_err), 32'(exp_err));
      model_accept(r, i, last);
    end
  endtask

  task automatic drain_wait();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: frame compare on handover, hold check while stalled
  initial begin
    logic [191:0] held;
    logic [191:0] cur;
    bit           have_hold;
    frame_t       e;
    have_hold = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_hold = 0;
      end else begin
        if (bus.frame_err) n_err_seen++;
        cur = {bus.x0_r, bus.x0_i, bus.x1_r, bus.x1_i, bus.x2_r, bus.x2_i,
               bus.x3_r, bus.x3_i, bus.tw1_r, bus.tw1_i, bus.tw2_r, bus.tw2_i};
        if (bus.out_valid && !bus.out_ready) begin
          if (have_hold) check("stall_outputs_stable", 32'(cur == held), 32'd1);
          else begin
            held = cur;
            have_hold = 1;
          end
        end else begin
          have_hold = 0;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got x0_r=%0h expected no frame", bus.x0_r);
          end else begin
            e = sb.pop_front();
            check("x0_r", 32'(bus.x0_r), 32'(e.s[0].re));
            check("x0_i", 32'(bus.x0_i), 32'(e.s[0].im));
            check("x1_r", 32'(bus.x1_r), 32'(e.s[1].re));
            check("x1_i", 32'(bus.x1_i), 32'(e.s[1].im));
            check("x2_r", 32'(bus.x2_r), 32'(e.s[2].re));
            check("x2_i", 32'(bus.x2_i), 32'(e.s[2].im));
            check("x3_r", 32'(bus.x3_r), 32'(e.s[3].re));
            check("x3_i", 32'(bus.x3_i), 32'(e.s[3].im));
            check("tw1_r", 32'(bus.tw1_r), 32'd256);
            check("tw1_i", 32'(bus.tw1_i), 32'd0);
            check("tw2_r", 32'(bus.tw2_r), 32'd256);
            check("tw2_i", 32'(bus.tw2_i), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    // Stimulus table: {r, i, last, frame_err expected right after accept}
    tbl[0]  = '{16'd1,      16'd0,      1'b0, 1'b0};
    tbl[1]  = '{16'd2,      16'd0,      1'b0, 1'b0};
    tbl[2]  = '{16'd3,      16'd0,      1'b0, 1'b0};
    tbl[3]  = '{16'd4,      16'd0,      1'b1, 1'b0};
    tbl[4]  = '{16'd10,     16'd5,      1'b0, 1'b0};
    tbl[5]  = '{16'd11,     16'd6,      1'b1, 1'b1};
    tbl[6]  = '{16'd20,     16'hFFFF,   1'b0, 1'b0};
    tbl[7]  = '{16'd21,     16'hFFFE,   1'b0, 1'b0};
    tbl[8]  = '{16'd22,     16'hFFFD,   1'b0, 1'b0};
    tbl[9]  = '{16'd23,     16'hFFFC,   1'b1, 1'b0};
    tbl[10] = '{16'd30,     16'd7,      1'b0, 1'b0};
    tbl[11] = '{16'd31,     16'd8,      1'b0, 1'b0};
    tbl[12] = '{16'd32,     16'd9,      1'b0, 1'b0};
    tbl[13] = '{16'd33,     16'd10,     1'b0, 1'b1};
    tbl[14] = '{16'h7FFF,   16'd1,      1'b0, 1'b0};
    tbl[15] = '{16'd3,      16'hFFFD,   1'b0, 1'b0};
    tbl[16] = '{16'hFFFD,   16'h8000,   1'b0, 1'b0};
    tbl[17] = '{16'h8000,   16'h7FFF,   1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_r      = '0;
    bus.in_i      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_x0_r", 32'(bus.x0_r), 32'd0);
    check("rst_x3_i", 32'(bus.x3_i), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Table-driven frames with the consumer always ready
    bus.out_ready = 1'b1;
    for (int k = 0; k < 18; k++) send(tbl[k].r, tbl[k].i, tbl[k].last, tbl[k].exp_err);
    drain_wait();

    // Backpressure: 8 samples fill both banks, the 9th must wait
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(16'(100 + k), 16'(200 + k), k % 4 == 3, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_r     = 16'd108;
    bus.in_i     = 16'd208;
    repeat (5) begin
      @(negedge clk);
      check("full_in_ready_low", 32'(bus.in_ready), 32'd0);
      check("full_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_before_drain", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_drain", 32'(bus.in_ready), 32'd1);
    for (int k = 8; k < 12; k++) send(16'(100 + k), 16'(200 + k), k == 11, 1'b0);
    drain_wait();

    // Reset with one full frame pending and a partial frame in progress
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) send(16'(300 + k), 16'(400 + k), k == 3, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    m_cnt = 0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_x0_r", 32'(bus.x0_r), 32'd0);
    check("midrst_x1_i", 32'(bus.x1_i), 32'd0);
    check("midrst_x3_r", 32'(bus.x3_r), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid_after", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(16'(500 + k), 16'hFFF0 + 16'(k), k == 3, 1'b0);
    drain_wait();

    repeat (3) @(posedge clk);
    #1;
    check("frame_err_pulse_count", 32'(n_err_seen), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft4_frame_loader.md
Name: fft4_frame_loader

Overview:
- Upstream input stage of the 4-point FFT datapath.
- Accepts complex Q-format samples one per cycle over a valid/ready stream and assembles them into 4-sample frames in a ping-pong buffer.
- Presents each frame in parallel, with its stage twiddles, to the radix-2x2 butterfly stage under a valid/ready handshake.

Parameters:
- N, 16, sample and twiddle word width, signed two's complement.
- Q, 8, fractional bits; unity twiddle = 1<<Q.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  loader can accept a sample.
- in_r  in  N  input sample, real part.
- in_i  in  N  input sample, imaginary part.
- in_last  in  1  marks 4th sample of a frame.
- out_valid  out  1  complete frame presented.
- out_ready  in  1  butterfly stage consumes frame.
- x0_r, x0_i, x1_r, x1_i, x2_r, x2_i, x3_r, x3_i  out  N each  frame samples 0..3, arrival order.
- tw1_r, tw1_i, tw2_r, tw2_i  out  N each  first-stage twiddles.
- frame_err  out  1  one-cycle pulse on framing error.

Behaviour:
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Two banks, each holding 4 complex registers and a state: EMPTY, FILLING or FULL.
- Write bank pointer wb; read bank pointer rb; sample counter cnt, 2 bits, 0..3.
- Each input transfer writes the sample to bank[wb][cnt] and increments cnt.
  - At cnt==3: bank[wb] goes to FULL, cnt wraps to 0, wb toggles.
- in_ready = bank[wb] != FULL. It is a purely registered-state function with no combinational path from out_ready.
- out_valid = bank[rb] == FULL.
- On output transfer: bank[rb] goes to EMPTY and rb toggles. in_ready can therefore rise no earlier than the cycle after the transfer.
- Latency: 4th sample accepted at edge T gives out_valid high after edge T. Sustained throughput is 1 frame per 4 cycles with out_ready held high.
- Stability: while out_valid & !out_ready, all x*/tw* outputs are held stable.
- Simultaneous fill of bank[wb] and drain of bank[rb] in the same cycle are both honoured.
- Both banks FULL: in_ready=0 and no sample is lost.
- Twiddles: first radix-2 stage uses W4^0.
  - tw1_r = tw2_r = 1<<Q (256 at defaults).
  - tw1_i = tw2_i = 0.
  - Driven constant from a package value.
- Framing:
  - in_last with cnt!=3: partial frame discarded, cnt reset to 0, bank stays EMPTY, frame_err pulses next cycle.
  - cnt==3 without in_last: frame completes normally, frame_err pulses.
- Reset (async, any time including mid-frame):
  - Banks EMPTY; cnt, wb and rb = 0.
  - out_valid=0, frame_err=0, all x* outputs 0.
  - in_ready=1 from the first cycle after deassertion.
  - Partial frames and unconsumed frames are dropped.
- Data outputs are muxed from bank[rb]. No arithmetic is performed unless the optional feature is enabled.

Optional Feature:
- Macro FRAME_SCALE_EN.
- Defined: each sample is scaled on capture as (v + 1) >>> 1 (arithmetic shift with round-half-up). Width stays N. The maximum positive value is saturated to avoid wrap, giving headroom for the butterfly growth.
- Undefined: samples are stored unmodified.

Decomposition:
- Shared package fft_pkg holds:
  - N_DEF and Q_DEF.
  - TW_ONE = 1<<Q.
  - Bank state typedef {EMPTY, FILLING, FULL}.
  - The complex sample struct.
- One natural sub-module: fft4_bank, a single 4-entry complex register bank with write index and state. It is instantiated twice.

Test Plan:
- Reset, then feed samples (1,0),(2,0),(3,0),(4,0) back-to-back with in_last on the 4th and out_ready=1 → out_valid after the 4th accept edge; x0_r..x3_r = 1,2,3,4; tw1_r = tw2_r = 256 and tw1_i = tw2_i = 0; frame_err never pulses.
- Hold out_ready=0 and stream 12 samples → 8 accepted, then in_ready=0; the first frame's outputs stay stable. Raise out_ready → frames drain in order and in_ready returns the cycle after the first drain.
- in_last asserted on the 2nd sample → frame_err pulses once, no out_valid. The next 4 samples form a correct frame.
- 4 samples without in_last → frame emitted and frame_err pulses one cycle.
- Assert rst after 2 samples of the second frame, with the first frame still unconsumed → out_valid=0 immediately and x* = 0. A subsequent clean frame is output correctly.
- With FRAME_SCALE_EN defined, inputs 0x7FFF, 3, -3 and 0x8000 → stored values 0x3FFF (saturated), 2, -1 and 0xC000.
